// File: rtl/fix_parser_tokenizer.sv
// FIX byte-stream tokenizer: splits fields on '=' and SOH, buffers each complete
// field and replays it as a framed tag/value burst; also checks tag 10 and reports bad fields.
module fix_parser_tokenizer #(
  parameter int unsigned TAG_MAX = 4,
  parameter int unsigned VAL_MAX = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid_i,
  input  logic [7:0] in_data_i,
  output logic       in_ready_o,
  output logic [7:0] data_o,
  output logic       start_tag_o,
  output logic       start_value_o,
  output logic       cks_valid_o,
  output logic       cks_ok_o,
  output logic       err_o,
  output logic [2:0] err_code_o
);

  localparam int unsigned TLW = $clog2(TAG_MAX + 1);
  localparam int unsigned VLW = $clog2(VAL_MAX + 1);
  localparam int unsigned TIW = $clog2(TAG_MAX);
  localparam int unsigned VIW = $clog2(VAL_MAX);

  localparam logic [7:0] CH_EQ  = 8'h3D;
  localparam logic [7:0] CH_SOH = 8'h01;

  localparam logic [2:0] ERR_TAG_OVF   = 3'd1;
  localparam logic [2:0] ERR_VAL_OVF   = 3'd2;
  localparam logic [2:0] ERR_TAG_CHR   = 3'd3;
  localparam logic [2:0] ERR_TAG_EMPTY = 3'd4;
  localparam logic [2:0] ERR_VAL_EMPTY = 3'd5;
  localparam logic [2:0] ERR_TAG_SOH   = 3'd6;

  typedef enum logic [2:0] {C_TAG, C_VAL, DISCARD, E_TAG, G1, E_VAL, G2} state_t;

  state_t         r_state;
  logic           r_in_ready;
  logic [7:0]     r_data;
  logic           r_start_tag;
  logic           r_start_value;
  logic           r_cks_valid;
  logic           r_cks_ok;
  logic           r_err;
  logic [2:0]     r_err_code;
  logic [7:0]     r_tag_buf [TAG_MAX];
  logic [7:0]     r_val_buf [VAL_MAX];
  logic [TLW-1:0] r_tag_len;
  logic [VLW-1:0] r_val_len;
  logic [VLW-1:0] r_idx;
  logic [7:0]     r_cks_acc;
  logic [7:0]     r_cks_base;
  logic           r_first;

  logic           w_accept;
  logic           w_is_digit;
  logic           w_is_cks_tag;
  logic           w_val_digits;
  logic           w_cks_match;
  logic [9:0]     w_val_dec;
  logic [TIW-1:0] w_tag_wi;
  logic [VIW-1:0] w_val_wi;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  assign in_ready_o    = r_in_ready;
  assign data_o        = r_data;
  assign start_tag_o   = r_start_tag;
  assign start_value_o = r_start_value;
  assign cks_valid_o   = r_cks_valid;
  assign cks_ok_o      = r_cks_ok;
  assign err_o         = r_err;
  assign err_code_o    = r_err_code;

  assign w_accept   = in_valid_i && r_in_ready;
  assign w_is_digit = is_digit(in_data_i);
  assign w_tag_wi   = r_tag_len[TIW-1:0];
  assign w_val_wi   = r_val_len[VIW-1:0];

  // Tag-10 detection and decimal decode of its 3-digit value
  assign w_is_cks_tag = (r_tag_len == TLW'(2)) && (r_tag_buf[0] == 8'h31) && (r_tag_buf[1] == 8'h30);
  assign w_val_digits = (r_val_len == VLW'(3)) && is_digit(r_val_buf[0]) &&
                        is_digit(r_val_buf[1]) && is_digit(r_val_buf[2]);
  assign w_val_dec    = 10'd100 * 10'(r_val_buf[0][3:0]) + 10'd10 * 10'(r_val_buf[1][3:0]) +
                        10'(r_val_buf[2][3:0]);
  assign w_cks_match  = w_val_digits && (w_val_dec == 10'(r_cks_base));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= C_TAG;
      r_in_ready    <= 1'b1;
      r_data        <= '0;
      r_start_tag   <= 1'b0;
      r_start_value <= 1'b0;
      r_cks_valid   <= 1'b0;
      r_cks_ok      <= 1'b0;
      r_err         <= 1'b0;
      r_err_code    <= '0;
      r_tag_len     <= '0;
      r_val_len     <= '0;
      r_idx         <= '0;
      r_cks_acc     <= '0;
      r_cks_base    <= '0;
      r_first       <= 1'b1;
      for (int i = 0; i < TAG_MAX; i++) r_tag_buf[i] <= '0;
      for (int i = 0; i < VAL_MAX; i++) r_val_buf[i] <= '0;
    end else begin
      r_cks_valid <= 1'b0;
      r_cks_ok    <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= '0;

      // Running checksum; base snapshots the sum preceding each field
      if (w_accept) begin
        r_cks_acc <= r_cks_acc + in_data_i;
        r_first   <= 1'b0;
        if (r_first) r_cks_base <= r_cks_acc;
      end

      case (r_state)
        C_TAG: if (w_accept) begin
          if (w_is_digit) begin
            if (r_tag_len == TLW'(TAG_MAX)) begin
              r_err      <= 1'b1;
              r_err_code <= ERR_TAG_OVF;
              r_state    <= DISCARD;
            end else begin
              r_tag_buf[w_tag_wi] <= in_data_i;
              r_tag_len           <= r_tag_len + TLW'(1);
            end
          end else if (in_data_i == CH_EQ) begin
            if (r_tag_len == '0) begin
              r_err      <= 1'b1;
              r_err_code <= ERR_TAG_EMPTY;
              r_state    <= DISCARD;
            end else begin
              r_state <= C_VAL;
            end
          end else if (in_data_i == CH_SOH) begin
            r_err      <= 1'b1;
            r_err_code <= ERR_TAG_SOH;
            r_tag_len  <= '0;
            r_val_len  <= '0;
            r_first    <= 1'b1;
          end else begin
            r_err      <= 1'b1;
            r_err_code <= ERR_TAG_CHR;
            r_state    <= DISCARD;
          end
        end

        C_VAL: if (w_accept) begin
          if (in_data_i != CH_SOH) begin
            if (r_val_len == VLW'(VAL_MAX)) begin
              r_err      <= 1'b1;
              r_err_code <= ERR_VAL_OVF;
              r_state    <= DISCARD;
            end else begin
              r_val_buf[w_val_wi] <= in_data_i;
              r_val_len           <= r_val_len + VLW'(1);
            end
          end else if (r_val_len == '0) begin
            r_err      <= 1'b1;
            r_err_code <= ERR_VAL_EMPTY;
            r_tag_len  <= '0;
            r_first    <= 1'b1;
            r_state    <= C_TAG;
          end else begin
            // Field complete: first tag byte goes out on the next cycle
            r_first     <= 1'b1;
            r_in_ready  <= 1'b0;
            r_data      <= r_tag_buf[0];
            r_start_tag <= 1'b1;
            r_idx       <= VLW'(1);
            r_state     <= E_TAG;
            if (w_is_cks_tag) begin
              r_cks_valid <= 1'b1;
              r_cks_ok    <= w_cks_match;
              r_cks_acc   <= '0;
            end
          end
        end

        DISCARD: if (w_accept && (in_data_i == CH_SOH)) begin
          r_tag_len <= '0;
          r_val_len <= '0;
          r_first   <= 1'b1;
          r_state   <= C_TAG;
        end

        E_TAG: begin
          if (r_idx < VLW'(r_tag_len)) begin
            r_data <= r_tag_buf[r_idx[TIW-1:0]];
            r_idx  <= r_idx + VLW'(1);
          end else begin
            r_data      <= '0;
            r_start_tag <= 1'b0;
            r_state     <= G1;
          end
        end

        G1: begin
          r_data        <= r_val_buf[0];
          r_start_value <= 1'b1;
          r_idx         <= VLW'(1);
          r_state       <= E_VAL;
        end

        E_VAL: begin
          if (r_idx < r_val_len) begin
            r_data <= r_val_buf[r_idx[VIW-1:0]];
            r_idx  <= r_idx + VLW'(1);
          end else begin
            r_data        <= '0;
            r_start_value <= 1'b0;
            r_state       <= G2;
          end
        end

        G2: begin
          r_tag_len  <= '0;
          r_val_len  <= '0;
          r_idx      <= '0;
          r_in_ready <= 1'b1;
          r_state    <= C_TAG;
        end

        default: begin
          r_in_ready <= 1'b1;
          r_state    <= C_TAG;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fix_parser_tokenizer.sv
// Directed bench for fix_parser_tokenizer: a table of FIX fields with expected
// tokens/errors/checksum results, plus a mid-burst reset sequence.
module tb_fix_parser_tokenizer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid_i;
  logic [7:0] in_data_i;
  logic       in_ready_o;
  logic [7:0] data_o;
  logic       start_tag_o;
  logic       start_value_o;
  logic       cks_valid_o;
  logic       cks_ok_o;
  logic       err_o;
  logic [2:0] err_code_o;

  always #5 clk = ~clk;

  fix_parser_tokenizer #(.TAG_MAX(4), .VAL_MAX(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid_i   (in_valid_i),
    .in_data_i    (in_data_i),
    .in_ready_o   (in_ready_o),
    .data_o       (data_o),
    .start_tag_o  (start_tag_o),
    .start_value_o(start_value_o),
    .cks_valid_o  (cks_valid_o),
    .cks_ok_o     (cks_ok_o),
    .err_o        (err_o),
    .err_code_o   (err_code_o)
  );

  // '|' in in_s stands for SOH
  typedef struct {
    string in_s;
    bit    tog;
    string exp_tag;
    string exp_val;
    int    exp_err;
    bit    exp_cv;
    bit    exp_ck;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Output observer (cumulative; the main thread diffs against snapshots)
  string s_tag = "";
  string s_val = "";
  int c_err = 0, last_code = 0, c_cv = 0, last_ck = 0, c_overlap = 0, c_gapbad = 0;
  int c_truns = 0, c_vruns = 0, c_lowruns = 0, last_run = 0, cur_run = 0;
  logic prev_st = 1'b0, prev_sv = 1'b0;

  always @(negedge clk) begin
    if (start_tag_o && start_value_o) c_overlap++;
    if (start_tag_o) begin
      if (!prev_st) c_truns++;
      s_tag = $sformatf("%s%c", s_tag, data_o);
    end
    if (start_value_o) begin
      if (!prev_sv) c_vruns++;
      s_val = $sformatf("%s%c", s_val, data_o);
    end
    if (!start_tag_o && !start_value_o && !in_ready_o && data_o != 8'h00) c_gapbad++;
    if (!in_ready_o) cur_run++;
    else if (cur_run != 0) begin
      last_run = cur_run;
      c_lowruns++;
      cur_run = 0;
    end
    if (err_o) begin c_err++; last_code = int'(err_code_o); end
    if (cks_valid_o) begin c_cv++; last_ck = int'(cks_ok_o); end
    prev_st = start_tag_o;
    prev_sv = start_value_o;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_s(input string nm, input string act, input string exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got \"%s\", expected \"%s\"", nm, act, exp);
    end
  endtask

  function automatic string tail(input string s, input int from);
    string r = "";
    for (int k = from; k < s.len(); k++) r = $sformatf("%s%c", r, s[k]);
    return r;
  endfunction

  function automatic vec_t mk(input string s, input bit tog, input string t, input string v,
                              input int e, input bit cv, input bit ck);
    vec_t r;
    r.in_s = s; r.tog = tog; r.exp_tag = t; r.exp_val = v;
    r.exp_err = e; r.exp_cv = cv; r.exp_ck = ck;
    return r;
  endfunction

  // Present one byte and hold it until accepted; called just after a negedge
  task automatic send_byte(input logic [7:0] b, input bit tog);
    bit acc = 1'b0;
    int guard = 0;
    if (tog) begin
      in_valid_i = 1'b0;
      @(negedge clk); #1;
    end
    in_valid_i = 1'b1;
    in_data_i  = b;
    while (!acc && guard < 100) begin
      acc = in_ready_o;
      @(negedge clk); #1;
      guard++;
    end
    if (!acc) begin
      n_cmp++; n_bad++;
      $display("FAIL send_byte: byte %0h not accepted, expected acceptance within 100 cycles", b);
    end
  endtask

  task automatic send_str(input string s, input bit tog);
    for (int k = 0; k < s.len(); k++) begin
      logic [7:0] b;
      b = s[k];
      if (b == 8'h7C) b = 8'h01;
      send_byte(b, tog);
    end
  endtask

  task automatic wait_idle(input string nm);
    int g = 0;
    int hi = 0;
    in_valid_i = 1'b0;
    while (hi < 3 && g < 200) begin
      @(negedge clk); #1;
      g++;
      if (in_ready_o) hi++; else hi = 0;
    end
    check({nm, " idle"}, (hi >= 3) ? 1 : 0, 1);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int b_tag, b_val, b_err, b_cv, b_ov, b_gap, b_tr, b_vr, b_lr;
    bit emit;
    b_tag = s_tag.len(); b_val = s_val.len(); b_err = c_err; b_cv = c_cv;
    b_ov = c_overlap; b_gap = c_gapbad; b_tr = c_truns; b_vr = c_vruns; b_lr = c_lowruns;
    emit = (v.exp_tag.len() > 0);
    send_str(v.in_s, v.tog);
    wait_idle(nm);
    check_s({nm, " tag"}, tail(s_tag, b_tag), v.exp_tag);
    check_s({nm, " value"}, tail(s_val, b_val), v.exp_val);
    check({nm, " err_pulses"}, c_err - b_err, (v.exp_err != 0) ? 1 : 0);
    if (v.exp_err != 0) check({nm, " err_code"}, last_code, v.exp_err);
    check({nm, " cks_valid_pulses"}, c_cv - b_cv, v.exp_cv);
    if (v.exp_cv) check({nm, " cks_ok"}, last_ck, v.exp_ck);
    check({nm, " flag_overlap"}, c_overlap - b_ov, 0);
    check({nm, " gap_data"}, c_gapbad - b_gap, 0);
    check({nm, " tag_runs"}, c_truns - b_tr, emit);
    check({nm, " value_runs"}, c_vruns - b_vr, emit);
    check({nm, " busy_runs"}, c_lowruns - b_lr, emit);
    if (emit) check({nm, " busy_len"}, last_run, v.exp_tag.len() + v.exp_val.len() + 2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500000, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    string s33, s32, v32;
    int g;

    rst = 1'b1; in_valid_i = 1'b0; in_data_i = 8'h00;

    s33 = "58="; s32 = "58="; v32 = "";
    for (int k = 0; k < 33; k++) s33 = $sformatf("%sA", s33);
    for (int k = 0; k < 32; k++) v32 = $sformatf("%sB", v32);
    s32 = $sformatf("%s%s|", s32, v32);
    s33 = $sformatf("%s|", s33);

    // Header sum of "8=FIX.4.2|9=5|35=0|" is 929, i.e. 161 mod 256
    vecs.push_back(mk("8=FIX.4.2|", 0, "8", "FIX.4.2", 0, 0, 0));
    vecs.push_back(mk("9=5|",       0, "9", "5",       0, 0, 0));
    vecs.push_back(mk("35=0|",      0, "35", "0",      0, 0, 0));
    vecs.push_back(mk("10=161|",    0, "10", "161",    0, 1, 1));
    vecs.push_back(mk("8=FIX.4.2|", 0, "8", "FIX.4.2", 0, 0, 0));
    vecs.push_back(mk("9=5|",       0, "9", "5",       0, 0, 0));
    vecs.push_back(mk("35=0|",      0, "35", "0",      0, 0, 0));
    vecs.push_back(mk("10=162|",    0, "10", "162",    0, 1, 0));
    vecs.push_back(mk("35=A|",      0, "35", "A",      0, 0, 0));
    vecs.push_back(mk("35=A|",      1, "35", "A",      0, 0, 0));
    vecs.push_back(mk("12345=X|",   0, "", "",         1, 0, 0));
    vecs.push_back(mk("1=Y|",       0, "1", "Y",       0, 0, 0));
    vecs.push_back(mk(s33,          0, "", "",         2, 0, 0));
    vecs.push_back(mk("58=|",       0, "", "",         5, 0, 0));
    vecs.push_back(mk("=5|",        0, "", "",         4, 0, 0));
    vecs.push_back(mk("3a=1|",      0, "", "",         3, 0, 0));
    vecs.push_back(mk("35|",        0, "", "",         6, 0, 0));
    vecs.push_back(mk("1234=Z|",    0, "1234", "Z",    0, 0, 0));
    vecs.push_back(mk(s32,          1, "58", v32,      0, 0, 0));
    vecs.push_back(mk("10=16|",     0, "10", "16",     0, 1, 0));
    vecs.push_back(mk("10=1x3|",    0, "10", "1x3",    0, 1, 0));

    repeat (2) @(negedge clk);
    #1;
    check("reset in_ready", in_ready_o, 1);
    check("reset data", data_o, 0);
    check("reset start_tag", start_tag_o, 0);
    check("reset start_value", start_value_o, 0);
    check("reset cks_valid", cks_valid_o, 0);
    check("reset cks_ok", cks_ok_o, 0);
    check("reset err", err_o, 0);
    check("reset err_code", err_code_o, 0);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset while the value of "55=IBM" is being replayed
    send_str("55=IBM|", 0);
    in_valid_i = 1'b0;
    g = 0;
    while (!start_value_o && g < 50) begin
      @(negedge clk); #1;
      g++;
    end
    check("midburst value seen", start_value_o, 1);
    rst = 1'b1;
    @(negedge clk); #1;
    check("midburst rst start_tag", start_tag_o, 0);
    check("midburst rst start_value", start_value_o, 0);
    check("midburst rst in_ready", in_ready_o, 1);
    check("midburst rst data", data_o, 0);
    rst = 1'b0;
    run_vec(mk("1=Y|", 0, "1", "Y", 0, 0, 0), "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fix_parser_tokenizer.md
Name: fix_parser_tokenizer

Overview:
Upstream stage of the FIX out-module. It accepts the raw FIX byte stream over a valid/ready handshake and splits it on '=' (0x3D) and SOH (0x01). Each complete field is buffered, then replayed as a gap-free burst on data_o with start_tag_o and start_value_o framing, which is what the tag/value extractor consumes. The block also checks the FIX checksum (tag 10) and reports malformed fields.

Parameters:
TAG_MAX, 4, maximum tag length in bytes (tag register downstream is 32 bits)
VAL_MAX, 32, maximum value length in bytes (value register downstream is 256 bits)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_valid_i  in  1  input byte valid
in_data_i  in  8  raw FIX byte
in_ready_o  out  1  block can accept a byte this cycle
data_o  out  8  replayed tag/value byte
start_tag_o  out  1  data_o carries a tag byte
start_value_o  out  1  data_o carries a value byte
cks_valid_o  out  1  one-cycle pulse: checksum field evaluated
cks_ok_o  out  1  checksum matched; qualified by cks_valid_o
err_o  out  1  one-cycle pulse: field dropped
err_code_o  out  3  1=tag overflow, 2=value overflow, 3=non-digit tag byte, 4=empty tag, 5=empty value, 6=SOH inside tag; qualified by err_o

Behaviour:
- Reset values: all outputs 0 except in_ready_o=1. Counters, buffers and checksum accumulator are cleared. State is C_TAG. Reset mid-burst aborts the burst immediately.
- A byte is accepted when in_valid_i && in_ready_o. in_ready_o=1 only in C_TAG, C_VAL and DISCARD.
- States:
  - C_TAG:
    - Digit byte: store in tag buffer, tag_len++.
    - '=' with tag_len==0: err 4, go to DISCARD.
    - '=' otherwise: go to C_VAL.
    - SOH: err 6, clear, stay in C_TAG.
    - Any other byte: err 3, go to DISCARD.
    - Storing a byte when tag_len==TAG_MAX: err 1, go to DISCARD.
  - C_VAL:
    - Any byte other than SOH: store, val_len++.
    - Storing a byte when val_len==VAL_MAX: err 2, go to DISCARD.
    - SOH with val_len==0: err 5, clear, go to C_TAG.
    - SOH otherwise: go to E_TAG.
  - DISCARD: consume bytes until SOH, then clear and go to C_TAG.
  - E_TAG: for tag_len cycles, data_o = tag bytes oldest first, start_tag_o=1. Then go to G1.
  - G1: one cycle with both flags 0, data_o=0. Then go to E_VAL.
  - E_VAL: for val_len cycles, data_o = value bytes oldest first, start_value_o=1. Then go to G2.
  - G2: one cycle with both flags 0. Clear lengths, go to C_TAG.
- Framing guarantee: start_tag_o and start_value_o are never high together. Each flag is contiguous for the whole tag or value, so input stalls never split a token downstream.
- Latency: first tag byte appears on data_o the cycle after the terminating SOH is accepted. Throughput is one field per (bytes in + tag_len + val_len + 2) cycles.
- Checksum:
  - cks_acc (8-bit, mod 256) adds every accepted byte, including '=' and SOH.
  - cks_base latches cks_acc at the first byte of each field.
  - For a field with tag "10" (0x31 0x30), the value must be exactly 3 ASCII digits. Decimal value D is compared with cks_base.
  - At E_TAG entry for that field: cks_valid_o=1 for one cycle, cks_ok_o=(D==cks_base). A wrong value length or a non-digit gives cks_ok_o=0.
  - cks_acc clears after the tag-10 field's SOH.
  - A dropped field's bytes still count in cks_acc.
  - The tag-10 field is always replayed downstream, regardless of checksum result.
- err_o is a single-cycle pulse on the cycle the offending byte is accepted. Bytes of a dropped field never appear on data_o.

Test Plan:
- "35=A<SOH>" with in_valid_i always 1 → in_ready_o low for 5 cycles after SOH. data_o sequence 0x33,0x35 (start_tag_o=1), gap, 0x41 (start_value_o=1), gap.
- Same field with in_valid_i toggling 1/0 every cycle → identical burst on data_o, flags contiguous.
- "8=FIX.4.2<SOH>9=5<SOH>35=0<SOH>10=ccc<SOH>" with the correct ccc → cks_valid_o=1, cks_ok_o=1. Repeat with ccc off by one → cks_ok_o=0, tag-10 field still emitted.
- "12345=X<SOH>" → err_o with code 1 on the fifth digit, nothing emitted. Following "1=Y<SOH>" emits normally.
- 33-byte value → err code 2. "58=<SOH>" → err code 5. "=5<SOH>" → err code 4. "3a=1<SOH>" → err code 3. None of these emit anything.
- Assert rst during E_VAL of "55=IBM<SOH>" → next cycle all flags 0, in_ready_o=1. A fresh field after reset is emitted correctly.
